// File: rtl/pe_result_drain_if.sv
// Beat stream from the PE result drain to the output buffer / DMA writer.
// The master drives data/valid/last; the slave answers with ready.
interface pe_result_drain_if #(
  parameter int ARRAY_NUM = 3
);
  logic [8*ARRAY_NUM-1:0] data;
  logic                   valid;
  logic                   ready;
  logic                   last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/pe_result_drain.sv
// PE block result drain.
// Snapshots the wide PE result bus on a capture strobe, asks the PE block to
// clear its accumulators, and streams the snapshot one array row per beat
// (block 0 first) over a valid/ready interface. Captures that arrive while a
// snapshot is still draining are dropped and counted, except one that lands
// exactly on the last-beat handshake, which reloads with no idle bubble.
module pe_result_drain #(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int CNT_W     = 8
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iCapture,
  input  logic [8*ARRAY_NUM*BLOCK_NUM-1:0] iResult,
  output logic                             oClearAcc,
  output logic                             oBusy,
  output logic                             oOverrun,
  output logic [CNT_W-1:0]                 oDropCount,
  pe_result_drain_if.master                beat_if
);

  localparam int BEAT_W = 8 * ARRAY_NUM;
  localparam int IDX_W  = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // State and snapshot
  logic [0:0]                            state_r;
  logic [IDX_W-1:0]                      idx_r;
  logic [BLOCK_NUM-1:0][BEAT_W-1:0]      shadow_r;

  // Registered outputs
  logic [BEAT_W-1:0]                     data_r;
  logic                                  valid_r;
  logic                                  last_r;
  logic                                  busy_r;
  logic                                  clear_r;
  logic                                  overrun_r;
  logic [CNT_W-1:0]                      drop_cnt_r;

  // Next-state values
  logic [0:0]                            state_nxt_s;
  logic [IDX_W-1:0]                      idx_nxt_s;
  logic [BLOCK_NUM-1:0][BEAT_W-1:0]      shadow_nxt_s;
  logic [BEAT_W-1:0]                     beat_nxt_s;
  logic                                  last_nxt_s;
  logic                                  accept_s;
  logic                                  drop_s;
  logic                                  hs_s;
  logic                                  at_last_s;

  // A beat is consumed when the current beat is presented and accepted.
  assign hs_s      = (state_r == ST_DRAIN) && beat_if.ready;
  assign at_last_s = (idx_r == LAST_IDX);

  // Drain FSM: decide next state, beat index and snapshot contents.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    shadow_nxt_s = shadow_r;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (iCapture) begin
          accept_s     = 1'b1;
          state_nxt_s  = ST_DRAIN;
          idx_nxt_s    = {IDX_W{1'b0}};
          shadow_nxt_s = iResult;
        end else begin
          state_nxt_s  = ST_IDLE;
          idx_nxt_s    = {IDX_W{1'b0}};
        end
      end
      ST_DRAIN: begin
        if (hs_s && at_last_s) begin
          // Last beat leaves this cycle: a coincident capture reloads at once.
          idx_nxt_s = {IDX_W{1'b0}};
          if (iCapture) begin
            accept_s     = 1'b1;
            state_nxt_s  = ST_DRAIN;
            shadow_nxt_s = iResult;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end else begin
          // Snapshot still in flight: any capture is lost.
          drop_s      = iCapture;
          state_nxt_s = ST_DRAIN;
          if (hs_s) begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end else begin
            idx_nxt_s = idx_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Beat presented next cycle, taken from the next snapshot so a reload shows
  // its block 0 immediately.
  generate
    if (BLOCK_NUM == 1) begin : g_one_block
      assign beat_nxt_s = shadow_nxt_s[0];
    end else begin : g_many_blocks
      assign beat_nxt_s = shadow_nxt_s[idx_nxt_s];
    end
  endgenerate

  assign last_nxt_s = (state_nxt_s == ST_DRAIN) && (idx_nxt_s == LAST_IDX);

  // State, snapshot and output registers; reset abandons any drain in progress.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      shadow_r   <= '0;
      data_r     <= {BEAT_W{1'b0}};
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      busy_r     <= 1'b0;
      clear_r    <= 1'b0;
      overrun_r  <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      shadow_r  <= shadow_nxt_s;
      valid_r   <= (state_nxt_s == ST_DRAIN);
      busy_r    <= (state_nxt_s == ST_DRAIN);
      last_r    <= last_nxt_s;
      clear_r   <= accept_s;
      overrun_r <= drop_s;
      if (state_nxt_s == ST_DRAIN) begin
        data_r <= beat_nxt_s;
      end else begin
        data_r <= {BEAT_W{1'b0}};
      end
      if (drop_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign beat_if.data  = data_r;
  assign beat_if.valid = valid_r;
  assign beat_if.last  = last_r;
  assign oClearAcc     = clear_r;
  assign oBusy         = busy_r;
  assign oOverrun      = overrun_r;
  assign oDropCount    = drop_cnt_r;

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: scoreboard of expected beats plus
// per-scenario inline checks on sideband outputs.
module tb_pe_result_drain;

  localparam int A  = 3;
  localparam int B  = 3;
  localparam int CW = 8;
  localparam int DW = 8 * A * B;
  localparam int BW = 8 * A;

  localparam logic [DW-1:0] R1 = 72'h090807_060504_030201;
  localparam logic [DW-1:0] R2 = 72'h111111_222222_333333;
  localparam logic [DW-1:0] RX = 72'hAAAAAA_BBBBBB_CCCCCC;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap;
  logic [DW-1:0] res;
  logic          clr, busy, ovr;
  logic [CW-1:0] dc;

  logic          cap1;
  logic [BW-1:0] res1;
  logic          clr1, busy1, ovr1;
  logic [CW-1:0] dc1;

  int total = 0;
  int bad   = 0;
  int clr_cnt = 0;
  int ovr_cnt = 0;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;

  pe_result_drain_if #(.ARRAY_NUM(A)) bif ();
  pe_result_drain_if #(.ARRAY_NUM(A)) bif1 ();

  pe_result_drain #(.ARRAY_NUM(A), .BLOCK_NUM(B), .CNT_W(CW)) dut (
    .iClk(clk), .iRst(rst), .iCapture(cap), .iResult(res),
    .oClearAcc(clr), .oBusy(busy), .oOverrun(ovr), .oDropCount(dc),
    .beat_if(bif)
  );

  pe_result_drain #(.ARRAY_NUM(A), .BLOCK_NUM(1), .CNT_W(CW)) dut1 (
    .iClk(clk), .iRst(rst), .iCapture(cap1), .iResult(res1),
    .oClearAcc(clr1), .oBusy(busy1), .oOverrun(ovr1), .oDropCount(dc1),
    .beat_if(bif1)
  );

  always #5 clk = ~clk;

  // Scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr) clr_cnt++;
    if (ovr) ovr_cnt++;
    if (!rst && bif.valid && bif.ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got data=%h last=%b, required no beat", bif.data, bif.last);
      end else begin
        exp_b = exp_q.pop_front();
        if (bif.data !== exp_b.d || bif.last !== exp_b.l) begin
          bad++;
          $display("FAIL sb_beat: got data=%h last=%b, required data=%h last=%b",
                   bif.data, bif.last, exp_b.d, exp_b.l);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_capture(input logic [DW-1:0] v);
    beat_t e;
    for (int b = 0; b < B; b++) begin
      e.d = v[b*BW +: BW];
      e.l = (b == B - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cap = 1'b0; res = '0; bif.ready = 1'b0;
    cap1 = 1'b0; res1 = '0; bif1.ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({bif.valid, busy, bif.last, clr, ovr} !== 5'b0) begin
      bad++; $display("FAIL rst_flags: got %b, required 00000", {bif.valid, busy, bif.last, clr, ovr});
    end
    total++;
    if (bif.data !== '0) begin bad++; $display("FAIL rst_data: got %h, required 0", bif.data); end
    total++;
    if (dc !== '0) begin bad++; $display("FAIL rst_dropcount: got %0d, required 0", dc); end
    total++;
    if ({bif1.valid, busy1, bif1.last} !== 3'b0) begin
      bad++; $display("FAIL rst_b1_flags: got %b, required 000", {bif1.valid, busy1, bif1.last});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream;
    int c0;
    c0 = clr_cnt;
    bif.ready = 1'b1;
    res = R1; cap = 1'b1; push_capture(R1);
    tick(); cap = 1'b0;
    total++;
    if (bif.valid !== 1'b1 || clr !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL t1_first: got valid=%b clr=%b busy=%b, required 1 1 1", bif.valid, clr, busy);
    end
    total++;
    if (bif.data !== 24'h030201 || bif.last !== 1'b0) begin
      bad++; $display("FAIL t1_beat0: got %h last=%b, required 030201 last=0", bif.data, bif.last);
    end
    tick();
    total++;
    if (clr !== 1'b0) begin bad++; $display("FAIL t1_clr_width: got %b, required 0", clr); end
    tick();
    total++;
    if (bif.data !== 24'h090807 || bif.last !== 1'b1) begin
      bad++; $display("FAIL t1_beat2: got %h last=%b, required 090807 last=1", bif.data, bif.last);
    end
    tick();
    total++;
    if (bif.valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t1_idle: got valid=%b busy=%b, required 0 0", bif.valid, busy);
    end
    total++;
    if (clr_cnt - c0 !== 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL t1_counts: got clr=%0d pending=%0d, required 1 0", clr_cnt - c0, exp_q.size());
    end
  endtask

  task automatic test_stall;
    logic          p [5];
    logic [BW-1:0] ed [5];
    p  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{24'h030201, 24'h060504, 24'h060504, 24'h060504, 24'h090807};
    res = R1; cap = 1'b1; push_capture(R1);
    tick(); cap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bif.valid !== 1'b1 || bif.data !== ed[i]) begin
        bad++; $display("FAIL t2_hold%0d: got valid=%b data=%h, required 1 %h", i, bif.valid, bif.data, ed[i]);
      end
      bif.ready = p[i];
      tick();
    end
    total++;
    if (bif.valid !== 1'b0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL t2_end: got valid=%b pending=%0d, required 0 0", bif.valid, exp_q.size());
    end
  endtask

  task automatic test_overrun;
    int c0, o0;
    c0 = clr_cnt; o0 = ovr_cnt;
    bif.ready = 1'b1;
    res = R1; cap = 1'b1; push_capture(R1);
    tick(); cap = 1'b0;
    tick();
    res = RX; cap = 1'b1;
    tick(); cap = 1'b0;
    total++;
    if (ovr !== 1'b1 || dc !== 8'd1) begin
      bad++; $display("FAIL t3_overrun: got ovr=%b dc=%0d, required 1 1", ovr, dc);
    end
    total++;
    if (bif.data !== 24'h090807) begin bad++; $display("FAIL t3_stream: got %h, required 090807", bif.data); end
    tick();
    total++;
    if (ovr !== 1'b0 || bif.valid !== 1'b0) begin
      bad++; $display("FAIL t3_after: got ovr=%b valid=%b, required 0 0", ovr, bif.valid);
    end
    total++;
    if (ovr_cnt - o0 !== 1 || clr_cnt - c0 !== 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL t3_counts: got ovr=%0d clr=%0d pending=%0d, required 1 1 0",
                      ovr_cnt - o0, clr_cnt - c0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int c0, o0;
    c0 = clr_cnt; o0 = ovr_cnt;
    bif.ready = 1'b1;
    res = R1; cap = 1'b1; push_capture(R1);
    tick(); cap = 1'b0;
    tick(); tick();
    total++;
    if (bif.last !== 1'b1) begin bad++; $display("FAIL t4_last: got %b, required 1", bif.last); end
    res = R2; cap = 1'b1; push_capture(R2);
    tick(); cap = 1'b0;
    total++;
    if (busy !== 1'b1 || bif.valid !== 1'b1 || clr !== 1'b1 || bif.data !== 24'h333333) begin
      bad++; $display("FAIL t4_reload: got busy=%b valid=%b clr=%b data=%h, required 1 1 1 333333",
                      busy, bif.valid, clr, bif.data);
    end
    tick(); tick();
    total++;
    if (bif.data !== 24'h111111 || bif.last !== 1'b1) begin
      bad++; $display("FAIL t4_beat2: got %h last=%b, required 111111 last=1", bif.data, bif.last);
    end
    tick();
    total++;
    if (bif.valid !== 1'b0 || clr_cnt - c0 !== 2 || ovr_cnt - o0 !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL t4_counts: got valid=%b clr=%0d ovr=%0d pending=%0d, required 0 2 0 0",
                      bif.valid, clr_cnt - c0, ovr_cnt - o0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    bif.ready = 1'b1;
    res = R1; cap = 1'b1; push_capture(R1);
    tick(); cap = 1'b0;
    tick();
    c0 = clr_cnt;
    rst = 1'b1;
    tick();
    total++;
    if (bif.valid !== 1'b0 || busy !== 1'b0 || bif.data !== '0 || dc !== '0) begin
      bad++; $display("FAIL t5_reset: got valid=%b busy=%b data=%h dc=%0d, required 0 0 0 0",
                      bif.valid, busy, bif.data, dc);
    end
    rst = 1'b0;
    exp_q.delete();
    tick();
    total++;
    if (clr_cnt !== c0 || bif.valid !== 1'b0) begin
      bad++; $display("FAIL t5_no_clr: got clr=%0d valid=%b, required %0d 0", clr_cnt, bif.valid, c0);
    end
    res = R2; cap = 1'b1; push_capture(R2);
    tick(); cap = 1'b0;
    total++;
    if (bif.data !== 24'h333333 || clr !== 1'b1) begin
      bad++; $display("FAIL t5_restart: got data=%h clr=%b, required 333333 1", bif.data, clr);
    end
    repeat (3) tick();
    total++;
    if (bif.valid !== 1'b0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL t5_end: got valid=%b pending=%0d, required 0 0", bif.valid, exp_q.size());
    end
  endtask

  task automatic test_saturation;
    int c0, o0;
    c0 = clr_cnt;
    bif.ready = 1'b0;
    res = R1; cap = 1'b1; push_capture(R1);
    tick();
    o0 = ovr_cnt;
    res = RX;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 254) begin
        total++;
        if (dc !== 8'd255) begin bad++; $display("FAIL t6_reach: got %0d, required 255", dc); end
      end
    end
    cap = 1'b0;
    tick();
    total++;
    if (dc !== 8'd255 || ovr_cnt - o0 !== 260) begin
      bad++; $display("FAIL t6_sat: got dc=%0d ovr=%0d, required 255 260", dc, ovr_cnt - o0);
    end
    total++;
    if (bif.data !== 24'h030201 || clr_cnt - c0 !== 1) begin
      bad++; $display("FAIL t6_stream: got data=%h clr=%0d, required 030201 1", bif.data, clr_cnt - c0);
    end
    bif.ready = 1'b1;
    repeat (3) tick();
    total++;
    if (bif.valid !== 1'b0 || exp_q.size() !== 0 || dc !== 8'd255) begin
      bad++; $display("FAIL t6_end: got valid=%b pending=%0d dc=%0d, required 0 0 255",
                      bif.valid, exp_q.size(), dc);
    end
  endtask

  task automatic test_single_block;
    bif1.ready = 1'b1;
    res1 = 24'hABCDEF; cap1 = 1'b1;
    tick(); cap1 = 1'b0;
    total++;
    if (bif1.valid !== 1'b1 || bif1.last !== 1'b1 || bif1.data !== 24'hABCDEF || clr1 !== 1'b1) begin
      bad++; $display("FAIL b1_beat: got valid=%b last=%b data=%h clr=%b, required 1 1 abcdef 1",
                      bif1.valid, bif1.last, bif1.data, clr1);
    end
    res1 = 24'h123456; cap1 = 1'b1;
    tick(); cap1 = 1'b0;
    total++;
    if (bif1.data !== 24'h123456 || bif1.last !== 1'b1 || busy1 !== 1'b1 || ovr1 !== 1'b0) begin
      bad++; $display("FAIL b1_b2b: got data=%h last=%b busy=%b ovr=%b, required 123456 1 1 0",
                      bif1.data, bif1.last, busy1, ovr1);
    end
    tick();
    total++;
    if (bif1.valid !== 1'b0 || busy1 !== 1'b0 || dc1 !== '0) begin
      bad++; $display("FAIL b1_idle: got valid=%b busy=%b dc=%0d, required 0 0 0", bif1.valid, busy1, dc1);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_single_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
